// File: rtl/cla_pkg.sv
// Shared constants and group-partitioning helpers for the two-level carry-lookahead adder.
package cla_pkg;

  localparam int GROUP_W = 4;

  // Number of lookahead groups needed to cover 'width' bits, LSB-first.
  function automatic int num_groups(input int width);
    return (width + GROUP_W - 1) / GROUP_W;
  endfunction

  // Bit count of group k; only the top group may be partial.
  function automatic int group_width(input int width, input int k);
    if (k < num_groups(width) - 1) begin
      return GROUP_W;
    end
    return width - GROUP_W * (num_groups(width) - 1);
  endfunction

endpackage

// File: rtl/cla_group4.sv
// First-level lookahead block of up to four bits: fully expanded internal carries,
// plus group-generate (gg) and group-propagate (gp) for the second-level unit.
module cla_group4 #(
  parameter int n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] s,
  output logic         gg,
  output logic         gp
);

  logic [n-1:0] g;
  logic [n-1:0] p;
  logic [n-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum of products of g, p and cin; no carry feeds another.
  always_comb begin : carry_expand
    logic term;
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    c    = '0;
    term = 1'b0;
    c[0] = cin;
    for (int i = 1; i < n; i++) begin
      term = cin;
      for (int m = 0; m < i; m++) term = term & p[m];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
  end

  assign s = p ^ c;

  // Kept apart from the carry block so gg/gp visibly depend on a and b only.
  always_comb begin : group_terms
    logic term;
    term = 1'b0;
    gp   = &p;
    gg   = 1'b0;
    for (int j = 0; j < n; j++) begin
      term = g[j];
      for (int m = j + 1; m < n; m++) term = term & p[m];
      gg = gg | term;
    end
  end

endmodule

// File: rtl/carry_look_ahead_adder.sv
// Registered two-level carry-lookahead adder: {cout, sum} = a + b + cin, one cycle latency.
// Optional macro CLA_OVERFLOW_EN adds a registered two's-complement overflow flag 'ovf'.
module carry_look_ahead_adder
  import cla_pkg::*;
#(
  parameter int width = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic [width-1:0] sum,
  output logic             cout,
`ifdef CLA_OVERFLOW_EN
  output logic             ovf,
`endif
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             cin
);

  localparam int NG = num_groups(width);

  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      carry;
  logic [width-1:0] sum_comb;

  logic [width-1:0] sum_d;
  logic [width-1:0] sum_q;
  logic             cout_d;
  logic             cout_q;

  for (genvar k = 0; k < NG; k++) begin : g_group
    localparam int LSB = k * GROUP_W;
    localparam int GW  = group_width(width, k);

    cla_group4 #(
      .n (GW)
    ) u_group (
      .a   (a[LSB +: GW]),
      .b   (b[LSB +: GW]),
      .cin (carry[k]),
      .s   (sum_comb[LSB +: GW]),
      .gg  (gg[k]),
      .gp  (gp[k])
    );
  end

  // Second-level lookahead: carry into group k is a direct function of cin and the
  // gg/gp of groups below it; carry[NG] is the adder's carry-out.
  always_comb begin : group_lookahead
    logic term;
    carry    = '0;
    term     = 1'b0;
    carry[0] = cin;
    for (int k = 1; k <= NG; k++) begin
      term = cin;
      for (int m = 0; m < k; m++) term = term & gp[m];
      carry[k] = term;
      for (int j = 0; j < k; j++) begin
        term = gg[j];
        for (int m = j + 1; m < k; m++) term = term & gp[m];
        carry[k] = carry[k] | term;
      end
    end
  end

  always_comb begin
    sum_d  = sum_comb;
    cout_d = carry[NG];
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef CLA_OVERFLOW_EN
  logic ovf_d;
  logic ovf_q;

  always_comb begin
    ovf_d = (a[width-1] == b[width-1]) && (sum_comb[width-1] != a[width-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Self-checking bench: directed corner vectors on width 10, reset behaviour, and a
// randomized back-to-back sweep over widths 1, 4, 7, 10 and 16 against plain arithmetic.
module tb_carry_look_ahead_adder;

  logic clk;
  logic rst;

  logic [0:0]  a1,  b1,  sum1;
  logic [3:0]  a4,  b4,  sum4;
  logic [6:0]  a7,  b7,  sum7;
  logic [9:0]  a10, b10, sum10;
  logic [15:0] a16, b16, sum16;
  logic cin1, cin4, cin7, cin10, cin16;
  logic cout1, cout4, cout7, cout10, cout16;
`ifdef CLA_OVERFLOW_EN
  logic ovf1, ovf4, ovf7, ovf10, ovf16;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;

  typedef struct packed {
    int a;
    int b;
    int cin;
    int sum;
    int cout;
    int ovf;
  } vec_t;

  vec_t dir_tbl [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CLA_OVERFLOW_EN
  carry_look_ahead_adder #(.width(1))  dut_w1  (.clk(clk), .rst(rst), .sum(sum1),  .cout(cout1),  .ovf(ovf1),  .a(a1),  .b(b1),  .cin(cin1));
  carry_look_ahead_adder #(.width(4))  dut_w4  (.clk(clk), .rst(rst), .sum(sum4),  .cout(cout4),  .ovf(ovf4),  .a(a4),  .b(b4),  .cin(cin4));
  carry_look_ahead_adder #(.width(7))  dut_w7  (.clk(clk), .rst(rst), .sum(sum7),  .cout(cout7),  .ovf(ovf7),  .a(a7),  .b(b7),  .cin(cin7));
  carry_look_ahead_adder #(.width(10)) dut_w10 (.clk(clk), .rst(rst), .sum(sum10), .cout(cout10), .ovf(ovf10), .a(a10), .b(b10), .cin(cin10));
  carry_look_ahead_adder #(.width(16)) dut_w16 (.clk(clk), .rst(rst), .sum(sum16), .cout(cout16), .ovf(ovf16), .a(a16), .b(b16), .cin(cin16));
`else
  carry_look_ahead_adder #(.width(1))  dut_w1  (.clk(clk), .rst(rst), .sum(sum1),  .cout(cout1),  .a(a1),  .b(b1),  .cin(cin1));
  carry_look_ahead_adder #(.width(4))  dut_w4  (.clk(clk), .rst(rst), .sum(sum4),  .cout(cout4),  .a(a4),  .b(b4),  .cin(cin4));
  carry_look_ahead_adder #(.width(7))  dut_w7  (.clk(clk), .rst(rst), .sum(sum7),  .cout(cout7),  .a(a7),  .b(b7),  .cin(cin7));
  carry_look_ahead_adder #(.width(10)) dut_w10 (.clk(clk), .rst(rst), .sum(sum10), .cout(cout10), .a(a10), .b(b10), .cin(cin10));
  carry_look_ahead_adder #(.width(16)) dut_w16 (.clk(clk), .rst(rst), .sum(sum16), .cout(cout16), .a(a16), .b(b16), .cin(cin16));
`endif

  // Width-10 signed overflow from integer arithmetic: result outside [-512, 511].
  function automatic logic ovf10_model(input logic [9:0] x, input logic [9:0] y, input logic c);
    int sx, sy, r;
    sx = x[9] ? int'(x) - 1024 : int'(x);
    sy = y[9] ? int'(y) - 1024 : int'(y);
    r  = sx + sy + int'(c);
    return (r > 511) || (r < -512);
  endfunction

  task automatic drive10(input logic [9:0] x, input logic [9:0] y, input logic c);
    @(negedge clk);
    a10 = x; b10 = y; cin10 = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a1 = '1; b1 = '1; cin1 = 1'b1;
    a4 = '1; b4 = '1; cin4 = 1'b1;
    a7 = '1; b7 = '1; cin7 = 1'b1;
    a10 = '1; b10 = '1; cin10 = 1'b1;
    a16 = '1; b16 = '1; cin16 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cnt++;
    if ({cout1, sum1} !== 2'd0) $display("FAIL reset_w1: got %0h expected 0", {cout1, sum1});
    else pass_cnt++;
    check_cnt++;
    if ({cout4, sum4} !== 5'd0) $display("FAIL reset_w4: got %0h expected 0", {cout4, sum4});
    else pass_cnt++;
    check_cnt++;
    if ({cout7, sum7} !== 8'd0) $display("FAIL reset_w7: got %0h expected 0", {cout7, sum7});
    else pass_cnt++;
    check_cnt++;
    if ({cout10, sum10} !== 11'd0) $display("FAIL reset_w10: got %0h expected 0", {cout10, sum10});
    else pass_cnt++;
    check_cnt++;
    if ({cout16, sum16} !== 17'd0) $display("FAIL reset_w16: got %0h expected 0", {cout16, sum16});
    else pass_cnt++;
`ifdef CLA_OVERFLOW_EN
    check_cnt++;
    if (ovf10 !== 1'b0) $display("FAIL reset_ovf10: got %0b expected 0", ovf10);
    else pass_cnt++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_directed;
    dir_tbl[0] = '{a: 55,    b: 421,   cin: 0, sum: 476,  cout: 0, ovf: 0};
    dir_tbl[1] = '{a: 1023,  b: 1,     cin: 0, sum: 0,    cout: 1, ovf: 0};
    dir_tbl[2] = '{a: 'h2AA, b: 'h155, cin: 0, sum: 1023, cout: 0, ovf: 0};
    dir_tbl[3] = '{a: 'h2AA, b: 'h155, cin: 1, sum: 0,    cout: 1, ovf: 0};
    dir_tbl[4] = '{a: 512,   b: 512,   cin: 1, sum: 1,    cout: 1, ovf: 1};
    for (int i = 0; i < 5; i++) begin
      drive10(10'(dir_tbl[i].a), 10'(dir_tbl[i].b), 1'(dir_tbl[i].cin));
      check_cnt++;
      if (sum10 !== 10'(dir_tbl[i].sum))
        $display("FAIL directed_sum[%0d]: got %0d expected %0d", i, sum10, dir_tbl[i].sum);
      else pass_cnt++;
      check_cnt++;
      if (cout10 !== 1'(dir_tbl[i].cout))
        $display("FAIL directed_cout[%0d]: got %0b expected %0d", i, cout10, dir_tbl[i].cout);
      else pass_cnt++;
`ifdef CLA_OVERFLOW_EN
      check_cnt++;
      if (ovf10 !== 1'(dir_tbl[i].ovf))
        $display("FAIL directed_ovf[%0d]: got %0b expected %0d", i, ovf10, dir_tbl[i].ovf);
      else pass_cnt++;
`endif
    end
  endtask

  task automatic test_mid_reset;
    drive10(10'd100, 10'd200, 1'b0);
    check_cnt++;
    if ({cout10, sum10} !== 11'd300) $display("FAIL pre_reset_sum: got %0d expected 300", {cout10, sum10});
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_cnt++;
    if ({cout10, sum10} !== 11'd0) $display("FAIL mid_reset_sum: got %0d expected 0", {cout10, sum10});
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_cnt++;
    if ({cout10, sum10} !== 11'd300) $display("FAIL post_reset_sum: got %0d expected 300", {cout10, sum10});
    else pass_cnt++;
  endtask

  // New vectors every cycle; each cycle's outputs are checked against the previous cycle's model.
  task automatic test_random_sweep;
    logic [1:0]  e1;
    logic [4:0]  e4;
    logic [7:0]  e7;
    logic [10:0] e10;
    logic [16:0] e16;
    logic        eovf;
    e1 = '0; e4 = '0; e7 = '0; e10 = '0; e16 = '0; eovf = 1'b0;
    for (int i = 0; i <= 1000; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_cnt++;
        if ({cout1, sum1} !== e1) $display("FAIL rand_w1 vec %0d: got %0h expected %0h", i, {cout1, sum1}, e1);
        else pass_cnt++;
        check_cnt++;
        if ({cout4, sum4} !== e4) $display("FAIL rand_w4 vec %0d: got %0h expected %0h", i, {cout4, sum4}, e4);
        else pass_cnt++;
        check_cnt++;
        if ({cout7, sum7} !== e7) $display("FAIL rand_w7 vec %0d: got %0h expected %0h", i, {cout7, sum7}, e7);
        else pass_cnt++;
        check_cnt++;
        if ({cout10, sum10} !== e10) $display("FAIL rand_w10 vec %0d: got %0h expected %0h", i, {cout10, sum10}, e10);
        else pass_cnt++;
        check_cnt++;
        if ({cout16, sum16} !== e16) $display("FAIL rand_w16 vec %0d: got %0h expected %0h", i, {cout16, sum16}, e16);
        else pass_cnt++;
`ifdef CLA_OVERFLOW_EN
        check_cnt++;
        if (ovf10 !== eovf) $display("FAIL rand_ovf10 vec %0d: got %0b expected %0b", i, ovf10, eovf);
        else pass_cnt++;
`endif
      end
      if (i < 1000) begin
        a1  = 1'($urandom);  b1  = 1'($urandom);  cin1  = 1'($urandom);
        a4  = 4'($urandom);  b4  = 4'($urandom);  cin4  = 1'($urandom);
        a7  = 7'($urandom);  b7  = 7'($urandom);  cin7  = 1'($urandom);
        a10 = 10'($urandom); b10 = 10'($urandom); cin10 = 1'($urandom);
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
        // Force a full-propagate operand pair now and then to stress long carry chains.
        if ($urandom_range(0, 7) == 0) begin
          b10 = ~a10;
          b16 = ~a16;
        end
        e1   = 2'(a1)   + 2'(b1)   + 2'(cin1);
        e4   = 5'(a4)   + 5'(b4)   + 5'(cin4);
        e7   = 8'(a7)   + 8'(b7)   + 8'(cin7);
        e10  = 11'(a10) + 11'(b10) + 11'(cin10);
        e16  = 17'(a16) + 17'(b16) + 17'(cin16);
        eovf = ovf10_model(a10, b10, cin10);
      end
      @(posedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_directed();
    test_mid_reset();
    test_random_sweep();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/carry_look_ahead_adder.md
Name: carry_look_ahead_adder

Overview:
- Parameterised two-level carry-lookahead adder: sum = a + b + cin, with carry-out.
- Combinational lookahead core; result registered once on the clock.
- General-purpose datapath arithmetic primitive. Default width is 10 bits.

Parameters:
- width, 10, operand and sum bit width; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- sum  output  width  registered sum, low width bits of a+b+cin
- cout  output  1  registered carry-out, bit width of a+b+cin
- a  input  width  operand A, unsigned
- b  input  width  operand B, unsigned
- cin  input  1  carry-in

Interface notes:
- One clock; reset is synchronous and active-high.
- Non-clock ports appear in the order sum, cout, a, b, cin.

Behaviour:
- Per bit: g[i] = a[i]&b[i]; p[i] = a[i]^b[i]; sum bit = p[i] ^ c[i]; c[0] = cin.
- Bits are partitioned into 4-bit groups from the LSB. The last group is partial when width is not a multiple of 4 (width 10 gives groups 4, 4, 2).
- Within a group: carries use full lookahead expansion, not ripple. The group emits group-generate GG and group-propagate GP.
- Across groups: each group carry-in is a second-level lookahead function of cin and lower-group GG/GP. No ripple between groups.
- cout = carry out of the top group.
- Latency 1 cycle: inputs sampled at rising edge N appear on sum/cout after edge N. Inputs are sampled every cycle; there is no handshake or enable.
- rst=1 at a rising edge: sum <= 0, cout <= 0. Reset overrides that cycle's inputs.
- Mid-stream reset: the output becomes 0 at the reset edge. After release, the first valid result appears one edge after release.
- Arithmetic is unsigned modulo 2^width. The full result is {cout, sum}, width+1 bits. No saturation.
- X/Z on inputs is not handled specially.

Optional Feature:
- Macro CLA_OVERFLOW_EN.
- When defined: extra output port ovf (1 bit, after cout), registered with the same latency and reset value 0.
  - ovf = (a[msb]==b[msb]) && (sum_comb[msb]!=a[msb]), i.e. two's-complement signed overflow.
- When undefined: the ovf port and its logic are absent.

Decomposition:
- Package cla_pkg holds:
  - constant GROUP_W = 4;
  - function num_groups(width) = ceil(width/4);
  - function group_width(width, k), the bit count of group k.
- One sub-module cla_group4: up to 4-bit lookahead block.
  - Parameter n (1..4).
  - Inputs a, b, cin.
  - Outputs s[n-1:0], GG, GP.
- Top level instantiates num_groups copies via generate and implements the inter-group lookahead unit plus output registers.

Test Plan:
- width=10, a=55, b=421, cin=0, one clock after reset release -> sum=476, cout=0.
- a=1023, b=1, cin=0 -> sum=0, cout=1 (carry crosses all three groups).
- a=0x2AA, b=0x155, cin=0 -> sum=1023, cout=0; same operands with cin=1 -> sum=0, cout=1 (full propagate chain).
- a=512, b=512, cin=1 -> sum=1, cout=1; with CLA_OVERFLOW_EN -> ovf=1.
- Drive a=100, b=200; assert rst for one edge -> sum=0, cout=0 at that edge; deassert -> sum=300 one edge later.
- Random sweep, width in {1,4,7,10,16}, 1000 vectors each -> {cout,sum} equals a+b+cin, one cycle delayed.
